uart_rx_buf: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 56 +++++
 rtl/uart_rx_buf.sv | 88 ++++++++
 tb/tb_uart_rx_buf.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive types, defaults and the parity-check helper.
package uart_pkg;

  localparam int UART_WORD_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;
  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int UART_PAR_MAX_W  = 32;

  typedef struct packed {
    logic [UART_WORD_WIDTH-1:0] data;
    logic                       parity_err;
    logic                       frame_err;
  } rx_entry_t;

  // Zero-extension does not change the XOR reduction, so one helper serves every width.
  function automatic logic parity_err(input logic [UART_PAR_MAX_W-1:0] data,
                                      input logic p, input logic odd, input logic en);
    return en & ((^data ^ p) != odd);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; occupancy counter drives full/empty.
module sync_fifo_fwft #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the slot a full-FIFO push needs in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_buf.sv
// UART receive buffer: word extraction, parity check and overrun tracking around a FWFT FIFO.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter  int WORD_WIDTH = UART_WORD_WIDTH,
  parameter  int DEPTH      = UART_FIFO_DEPTH,
  localparam int CW         = $clog2(DEPTH+1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORD_WIDTH:0]   i_rx_word,
  input  logic                  i_rx_done,
  input  logic                  i_rx_frame_err,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_flush,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_overrun,
  input  logic                  i_clr_overrun
);

  // Same layout as rx_entry_t, sized by this instance's WORD_WIDTH.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  parity_err;
    logic                  frame_err;
  } entry_t;

  entry_t                w_entry_in;
  entry_t                w_entry_out;
  logic [WORD_WIDTH-1:0] w_data;
  logic                  w_push_evt;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  r_overrun;

  // Without parity the stop-side bit shifts in at the top, leaving data one bit up.
  assign w_data     = i_parity_en ? i_rx_word[WORD_WIDTH-1:0] : i_rx_word[WORD_WIDTH:1];
  assign w_push_evt = i_rx_done | i_rx_frame_err;

  always_comb begin
    w_entry_in            = '0;
    w_entry_in.data       = w_data;
    w_entry_in.parity_err = parity_err(UART_PAR_MAX_W'(w_data), i_rx_word[WORD_WIDTH],
                                       i_parity_odd, i_parity_en);
    w_entry_in.frame_err  = i_rx_frame_err;
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push_evt),
    .i_wdata (w_entry_in),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .o_rdata (w_entry_out),
    .o_count (o_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_valid = ~w_empty;
  assign w_pop   = o_valid & i_ready;

  // A flushed word is discarded by the flush, not dropped by overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                         r_overrun <= 1'b0;
    else if (w_push_evt && w_full && !w_pop && !i_flush) r_overrun <= 1'b1;
    else if (i_clr_overrun)                            r_overrun <= 1'b0;
  end

  assign o_data       = w_entry_out.data;
  assign o_parity_err = w_entry_out.parity_err;
  assign o_frame_err  = w_entry_out.frame_err;
  assign o_full       = w_full;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf: single-entry vector table plus full/overrun/flush/reset sequences.
module tb_uart_rx_buf;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W:0]    rx_word;
  logic          rx_done, rx_ferr, par_en, par_odd, flush, ready, clr_ovr;
  logic          valid, perr, ferr, full, overrun;
  logic [W-1:0]  data;
  logic [CW-1:0] count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  uart_rx_buf #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_word(rx_word), .i_rx_done(rx_done),
    .i_rx_frame_err(rx_ferr), .i_parity_en(par_en), .i_parity_odd(par_odd),
    .i_flush(flush), .i_ready(ready), .o_valid(valid), .o_data(data),
    .o_parity_err(perr), .o_frame_err(ferr), .o_count(count), .o_full(full),
    .o_overrun(overrun), .i_clr_overrun(clr_ovr)
  );

  typedef struct {
    logic [W:0]   word;
    logic         done;
    logic         fe;
    logic         pen;
    logic         podd;
    logic [W-1:0] exp_data;
    logic         exp_perr;
    logic         exp_fe;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    rx_word = {d, 1'b0};
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_word = '0; rx_done = 0; rx_ferr = 0; par_en = 0; par_odd = 0;
    flush = 0; ready = 0; clr_ovr = 0;

    vecs[0] = '{9'h1A5, 1, 0, 0, 0, 8'hD2, 0, 0};
    vecs[1] = '{9'h155, 1, 0, 1, 0, 8'h55, 1, 0};
    vecs[2] = '{9'h155, 1, 0, 1, 1, 8'h55, 0, 0};
    vecs[3] = '{9'h000, 0, 1, 0, 0, 8'h00, 0, 1};
    vecs[4] = '{9'h0AA, 1, 0, 1, 0, 8'hAA, 0, 0};
    vecs[5] = '{9'h1FF, 1, 1, 1, 1, 8'hFF, 0, 1};
    vecs[6] = '{9'h0B7, 1, 0, 1, 1, 8'hB7, 1, 0};

    tick(); tick();
    rst = 1'b0;
    chk("reset_valid", valid, 0);
    chk("reset_count", count, 0);
    chk("reset_full", full, 0);
    chk("reset_overrun", overrun, 0);

    for (int i = 0; i < 7; i++) begin
      rx_word = vecs[i].word; rx_done = vecs[i].done; rx_ferr = vecs[i].fe;
      par_en = vecs[i].pen; par_odd = vecs[i].podd;
      tick();
      rx_done = 0; rx_ferr = 0;
      // Flipping parity config after the push must not alter the stored flag.
      par_odd = ~par_odd; par_en = ~par_en;
      chk($sformatf("v%0d_valid", i), valid, 1);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      chk($sformatf("v%0d_perr", i), perr, vecs[i].exp_perr);
      chk($sformatf("v%0d_ferr", i), ferr, vecs[i].exp_fe);
      chk($sformatf("v%0d_count", i), count, 1);
      ready = 1; tick(); ready = 0;
      chk($sformatf("v%0d_popped", i), count, 0);
    end
    par_en = 0; par_odd = 0;

    // Fill, overflow (with a same-cycle clear that must lose), drain in order.
    for (int i = 0; i < D; i++) push_word(W'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, D);
    chk("fill_overrun", overrun, 0);
    clr_ovr = 1; push_word(8'h99); clr_ovr = 0;
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, D);
    ready = 1;
    for (int i = 0; i < D; i++) begin
      chk($sformatf("drain%0d_valid", i), valid, 1);
      chk($sformatf("drain%0d_data", i), data, i);
      tick();
    end
    ready = 0;
    chk("drain_empty", valid, 0);
    chk("drain_overrun_sticky", overrun, 1);

    // Flush with a simultaneous push; overrun must survive.
    for (int i = 0; i < 5; i++) push_word(8'h30 + W'(i));
    chk("pre_flush_count", count, 5);
    flush = 1; push_word(8'h77); flush = 0;
    chk("flush_count", count, 0);
    chk("flush_valid", valid, 0);
    chk("flush_overrun", overrun, 1);
    push_word(8'h42);
    chk("post_flush_count", count, 1);
    chk("post_flush_data", data, 8'h42);
    clr_ovr = 1; tick(); clr_ovr = 0;
    chk("clr_overrun", overrun, 0);
    ready = 1; tick(); ready = 0;

    // Full FIFO with push and pop together.
    for (int i = 0; i < D; i++) push_word(8'h10 + W'(i));
    ready = 1; push_word(8'hEE); ready = 0;
    chk("fullpp_count", count, D);
    chk("fullpp_overrun", overrun, 0);
    chk("fullpp_head", data, 8'h11);
    ready = 1;
    for (int i = 0; i < D; i++) begin
      chk($sformatf("fullpp%0d_data", i), data, (i == D-1) ? 8'hEE : 8'h11 + i);
      tick();
    end
    ready = 0;
    chk("fullpp_empty", count, 0);

    // Reset mid-traffic, including a push and overrun in the same cycle.
    for (int i = 0; i < D; i++) push_word(W'(i));
    push_word(8'h55);
    chk("pre_rst_overrun", overrun, 1);
    rst = 1; push_word(8'h66); rst = 0;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
